// File: rtl/btn_cond_pkg.sv
// Shared types and default timing for the push-button conditioner.
//   state_e    : 3-bit debounce/repeat FSM encoding
//   DEF_*      : default timing constants for a 100 MHz clk
//                (10 ms debounce, 500 ms first repeat, 100 ms repeat period)
package btn_cond_pkg;

   typedef enum logic [2:0] {
      RELEASED  = 3'd0,
      ARMING    = 3'd1,
      PRESSED   = 3'd2,
      REPEATING = 3'd3,
      DISARMING = 3'd4
   } state_e;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
   localparam int unsigned DEF_REPEAT_RATE     = 10_000_000;
   localparam int unsigned DEF_CNT_W           = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
//   clk     : destination clock
//   reset_n : async active-low reset, both flops clear to 0
//   d_i     : asynchronous input
//   q_o     : synchronised output, two clk edges of latency
module sync_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Turns one raw push-button into a debounced level plus single-cycle
// press / release / auto-repeat strobes for the up/down counter.
//   clk           : system clock
//   reset_n       : async active-low reset
//   btn_in        : raw button, asynchronous, active-high
//   level_out     : debounced level
//   press_pulse   : 1-cycle strobe on accepted press
//   release_pulse : 1-cycle strobe on accepted release
//   repeat_pulse  : 1-cycle strobe on each auto-repeat while held
//   step_pulse    : press_pulse | repeat_pulse
module button_conditioner
   import btn_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic level_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic step_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

   logic             sync;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             repeat_q, repeat_d;
   logic             step_q;

   sync_2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (btn_in),
      .q_o     (sync)
   );

   // Saturating increment: a held button must never wrap the timer back
   // into a compare window.
   assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_inc;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
         RELEASED: begin
            timer_d = '0;
            if (sync) state_d = ARMING;
         end
         ARMING: begin
            if (!sync) begin
               state_d = RELEASED;
               timer_d = '0;
            end else if (timer_q == DB_LAST) begin
               state_d = PRESSED;
               timer_d = '0;
               press_d = 1'b1;
               level_d = 1'b1;
            end
         end
         PRESSED: begin
            if (!sync) begin
               state_d = DISARMING;
               timer_d = '0;
            end else if (REPEAT_EN != 0 && timer_q == DLY_LAST) begin
               state_d  = REPEATING;
               timer_d  = '0;
               repeat_d = 1'b1;
            end
         end
         REPEATING: begin
            if (!sync) begin
               state_d = DISARMING;
               timer_d = '0;
            end else if (timer_q == RATE_LAST) begin
               timer_d  = '0;
               repeat_d = 1'b1;
            end
         end
         DISARMING: begin
            // A bounce back high resumes the hold; the repeat delay restarts.
            if (sync) begin
               state_d = PRESSED;
               timer_d = '0;
            end else if (timer_q == DB_LAST) begin
               state_d   = RELEASED;
               timer_d   = '0;
               release_d = 1'b1;
               level_d   = 1'b0;
            end
         end
         default: begin
            state_d = RELEASED;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RELEASED;
         timer_q   <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         step_q    <= press_d | repeat_d;
      end
   end

   assign level_out     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;
   assign step_pulse    = step_q;

endmodule
